// File: rtl/vga_sync_decoder.sv
// Recovers 640x480@60 pixel coordinates, active-video and lock status from oversampled h_sync/v_sync.
// Optional macro VGA_SYNC_ERROR_COUNT_EN adds a saturating count of lock losses on port error_count.
module vga_sync_decoder #(
    parameter int clk_freq   = 50000000,
    parameter int tolerance  = 4,
    parameter int lock_lines = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] h_pixel,
    output logic [8:0] v_pixel,
    output logic       active,
    output logic       locked,
    output logic       frame_start
`ifdef VGA_SYNC_ERROR_COUNT_EN
    ,
    output logic [7:0] error_count
`endif
);

    localparam int DIV    = clk_freq / 25000000;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GOOD_W = $clog2(lock_lines + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [GOOD_W-1:0]  LOCK_N      = GOOD_W'(lock_lines);
    localparam logic [15:0]        TIMEOUT_CNT = 16'(2 * 800 * DIV);
    localparam logic signed [17:0] LINE_S      = 18'(800 * DIV);
    localparam logic signed [17:0] TOL_S       = 18'(tolerance);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic within_tol(input logic signed [17:0] d);
        within_tol = (d <= TOL_S) && (d >= -TOL_S);
    endfunction

    logic h_sync_p0, h_sync_p1, h_sync_p2, hfe_p3;
    logic v_sync_p0, v_sync_p1, v_sync_p2, vfe_p3, vfe_p4;

    logic [15:0]      period;
    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_count;
    logic [9:0]       line_count;
    logic             seen_h, seen_v;

    state_t            state, state_nx;
    logic [GOOD_W-1:0] good_cnt, good_cnt_nx;
    logic              unlock;

    logic signed [17:0] dev;
    logic [10:0]        lines;
    logic               line_eval, line_good, line_bad, frame_bad, timeout;
    logic               in_h, in_v, act_nx;

    // Stage p0..p3: two-flop synchronizers, edge register and registered falling-edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync_p0 <= 1'b1;
            h_sync_p1 <= 1'b1;
            h_sync_p2 <= 1'b1;
            v_sync_p0 <= 1'b1;
            v_sync_p1 <= 1'b1;
            v_sync_p2 <= 1'b1;
            hfe_p3    <= 1'b0;
            vfe_p3    <= 1'b0;
        end else begin
            h_sync_p0 <= h_sync;
            h_sync_p1 <= h_sync_p0;
            h_sync_p2 <= h_sync_p1;
            v_sync_p0 <= v_sync;
            v_sync_p1 <= v_sync_p0;
            v_sync_p2 <= v_sync_p1;
            hfe_p3    <= h_sync_p2 & ~h_sync_p1;
            vfe_p3    <= v_sync_p2 & ~v_sync_p1;
        end
    end

    // Stage p4: line/pixel counters driven by the edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            period     <= 16'd0;
            div_cnt    <= '0;
            h_count    <= 10'd0;
            line_count <= 10'd0;
            seen_h     <= 1'b0;
            seen_v     <= 1'b0;
            vfe_p4     <= 1'b0;
        end else begin
            seen_h <= seen_h | hfe_p3;
            seen_v <= seen_v | vfe_p3;
            vfe_p4 <= vfe_p3;
            if (hfe_p3) begin
                period  <= 16'd1;
                div_cnt <= '0;
                h_count <= 10'd0;
            end else begin
                period <= sat_inc16(period);
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    h_count <= sat_inc10(h_count);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
            if (vfe_p3)
                line_count <= 10'd0;
            else if (hfe_p3)
                line_count <= sat_inc10(line_count);
        end
    end

    // The very first edge after reset has no reference, so it only arms the checks.
    always_comb begin
        dev       = $signed({2'b00, period}) - LINE_S;
        line_eval = hfe_p3 & seen_h;
        line_good = within_tol(dev);
        line_bad  = line_eval & ~line_good;
        lines     = {1'b0, line_count} + {10'd0, hfe_p3};
        frame_bad = vfe_p3 & seen_v & (lines != 11'd525);
        timeout   = (period >= TIMEOUT_CNT) & ~hfe_p3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        good_cnt_nx = good_cnt;
        unlock      = 1'b0;
        case (state)
            SEARCH: begin
                if (good_cnt == LOCK_N) begin
                    state_nx    = LOCKED;
                    good_cnt_nx = '0;
                end else if (line_eval) begin
                    good_cnt_nx = line_good ? good_cnt + GOOD_W'(1) : '0;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || timeout) begin
                    state_nx    = SEARCH;
                    good_cnt_nx = '0;
                    unlock      = 1'b1;
                end
            end
            default: begin
                state_nx    = SEARCH;
                good_cnt_nx = '0;
            end
        endcase
    end

    assign locked = (state == LOCKED);

    always_comb begin
        in_h   = (h_count >= 10'd144) && (h_count <= 10'd783);
        in_v   = (line_count >= 10'd35) && (line_count <= 10'd514);
        act_nx = in_h & in_v & locked;
    end

    // Stage p5: registered pixel outputs, one clock behind the counters
    always_ff @(posedge clk) begin
        if (reset) begin
            active      <= 1'b0;
            h_pixel     <= 10'd0;
            v_pixel     <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            active      <= act_nx;
            h_pixel     <= act_nx ? h_count - 10'd144 : 10'd0;
            v_pixel     <= act_nx ? 9'(line_count - 10'd35) : 9'd0;
            frame_start <= vfe_p4 & locked;
        end
    end

`ifdef VGA_SYNC_ERROR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            error_count <= 8'd0;
        else if (unlock && (error_count != 8'hFF))
            error_count <= error_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder at DIV=2: lock, pixel recovery, tolerance edges, frame checks, timeout, reset.
module tb_vga_sync_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       h_sync = 1'b1;
    logic       v_sync = 1'b1;
    logic [9:0] h_pixel;
    logic [8:0] v_pixel;
    logic       active, locked, frame_start;
`ifdef VGA_SYNC_ERROR_COUNT_EN
    logic [7:0] error_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rel      = 100;
    int vrel     = 100;
    int act_cnt  = 0;
    int lock_cnt = 0;
    int act0, lock0;

    vga_sync_decoder #(.clk_freq(50000000), .tolerance(4), .lock_lines(4)) dut (
        .clk(clk),
        .reset(reset),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .h_pixel(h_pixel),
        .v_pixel(v_pixel),
        .active(active),
        .locked(locked),
        .frame_start(frame_start)
`ifdef VGA_SYNC_ERROR_COUNT_EN
        ,
        .error_count(error_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        act_cnt  <= act_cnt + (active ? 1 : 0);
        lock_cnt <= lock_cnt + (locked ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sync pins return high 4 clocks after their falling edge.
    task automatic step1;
        @(posedge clk);
        #1;
        rel++;
        vrel++;
        if (rel == 4) h_sync = 1'b1;
        if (vrel == 4) v_sync = 1'b1;
    endtask

    task automatic hfall;
        h_sync = 1'b0;
        rel    = 0;
    endtask

    task automatic vfall;
        v_sync = 1'b0;
        vrel   = 0;
    endtask

    // Returns just after edge e, counting the first edge after the last h fall as edge 0.
    task automatic adv_to(input int e);
        while (rel < e + 1) step1();
    endtask

    task automatic hline(input int p);
        hfall();
        adv_to(p - 1);
    endtask

    task automatic check_ec(input string tag, input int exp);
`ifdef VGA_SYNC_ERROR_COUNT_EN
        check(tag, 32'(error_count), 32'(exp));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_h_pixel"}, 32'(h_pixel), 32'd0);
        check({tag, "_v_pixel"}, 32'(v_pixel), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check_ec({tag, "_error_count"}, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) step1();
        check_all_zero("reset");
        reset = 1'b0;
        step1();

        // v_sync alone never locks
        act0  = act_cnt;
        lock0 = lock_cnt;
        repeat (3) begin
            vfall();
            repeat (50) step1();
        end
        check("vsync_only_locked", 32'(locked), 32'd0);

        // Periods 1610,1610,1605,1595: all outside tolerance
        hline(1610);
        hline(1610);
        hline(1605);
        hline(1595);
        hfall();
        adv_to(7);
        check("bad_period_never_locked", 32'(lock_cnt - lock0), 32'd0);
        check("bad_period_never_active", 32'(act_cnt - act0), 32'd0);

        // Fast-forward to line 30, then 4 good periods (boundaries 1604/1596 included)
        repeat (25) hline(8);
        hline(1604);
        hline(1596);
        hline(1600);
        hline(1604);
        hfall();
        adv_to(3);
        check("lock_not_yet", 32'(locked), 32'd0);
        adv_to(4);
        check("lock_rise", 32'(locked), 32'd1);
        adv_to(291);
        check("pre_active_col143", 32'(active), 32'd0);
        adv_to(292);
        check("first_active", 32'(active), 32'd1);
        check("first_h_pixel", 32'(h_pixel), 32'd0);
        check("first_v_pixel", 32'(v_pixel), 32'd0);
        adv_to(294);
        check("h_pixel_1", 32'(h_pixel), 32'd1);
        adv_to(1571);
        check("h_pixel_639", 32'(h_pixel), 32'd639);
        check("active_col639", 32'(active), 32'd1);
        adv_to(1572);
        check("after_col639_active", 32'(active), 32'd0);
        check("after_col639_h_pixel", 32'(h_pixel), 32'd0);
        adv_to(1599);

        // Short line while locked drops lock
        hline(8);
        hfall();
        adv_to(2);
        check("bad_line_still_locked", 32'(locked), 32'd1);
        adv_to(3);
        check("bad_line_unlock", 32'(locked), 32'd0);
        check_ec("ec_bad_line", 1);
        adv_to(7);

        // Fast-forward to line 509, relock on line 514 and read the last visible row
        repeat (472) hline(8);
        repeat (4) hline(1600);
        hfall();
        adv_to(3);
        check("relock514_not_yet", 32'(locked), 32'd0);
        adv_to(292);
        check("row479_active", 32'(active), 32'd1);
        check("row479_v_pixel", 32'(v_pixel), 32'd479);
        check("row479_h_pixel", 32'(h_pixel), 32'd0);
        adv_to(1571);
        check("row479_max_h", 32'(h_pixel), 32'd639);
        check("row479_max_v", 32'(v_pixel), 32'd479);
        adv_to(1599);
        hfall();
        adv_to(292);
        check("row515_inactive", 32'(active), 32'd0);
        check("row515_v_pixel", 32'(v_pixel), 32'd0);
        adv_to(1599);
        repeat (9) hline(1600);

        // v_sync coincident with the h_sync edge that closes line 524: 525 lines, accepted
        vfall();
        hfall();
        adv_to(3);
        check("fs_not_yet", 32'(frame_start), 32'd0);
        adv_to(4);
        check("frame_start_pulse", 32'(frame_start), 32'd1);
        check("good_frame_locked", 32'(locked), 32'd1);
        adv_to(5);
        check("frame_start_one_cycle", 32'(frame_start), 32'd0);
        adv_to(7);

        // Unlock, fast-forward, relock on line 522, then close a 524-line frame
        repeat (517) hline(8);
        check("ff_unlocked", 32'(locked), 32'd0);
        check_ec("ec_ff_unlock", 2);
        repeat (4) hline(1600);
        hfall();
        adv_to(3);
        check("relock522_not_yet", 32'(locked), 32'd0);
        adv_to(4);
        check("relock522", 32'(locked), 32'd1);
        adv_to(1599);
        hline(1600);
        vfall();
        hfall();
        adv_to(2);
        check("short_frame_still_locked", 32'(locked), 32'd1);
        adv_to(3);
        check("short_frame_unlock", 32'(locked), 32'd0);
        check_ec("ec_short_frame", 3);
        adv_to(1599);

        // Relock, then reset mid-line while locked
        repeat (3) hline(1600);
        hfall();
        adv_to(4);
        check("pre_reset_locked", 32'(locked), 32'd1);
        adv_to(500);
        reset = 1'b1;
        adv_to(501);
        reset = 1'b0;
        check_all_zero("mid_reset");

        // First edge after reset would measure exactly 1600 clk, yet must not count
        adv_to(2098);
        repeat (3) hline(1600);
        hfall();
        adv_to(4);
        check("post_reset_3_good", 32'(locked), 32'd0);
        adv_to(1599);
        hfall();
        adv_to(3);
        check("post_reset_4_good_pending", 32'(locked), 32'd0);
        adv_to(4);
        check("post_reset_relock", 32'(locked), 32'd1);

        // h_sync held high: lock drops once period reaches 3200
        adv_to(3202);
        check("timeout_pending", 32'(locked), 32'd1);
        adv_to(3203);
        check("timeout_unlock", 32'(locked), 32'd0);
        adv_to(3204);
        check("timeout_inactive", 32'(active), 32'd0);
        check_ec("ec_timeout", 1);
        adv_to(3300);
        check("timeout_stays_unlocked", 32'(locked), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
